// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream mux: default sizing,
// a constant clog2 helper and the channel-slice index macro.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

// Bit offset of channel idx inside a flat bus of w-bit channels.
`define MUX_SLICE(idx, w) ((idx) * (w))

package mux_pkg;

  localparam int DEFAULT_N_CH  = 4;
  localparam int DEFAULT_WIDTH = 4;

  // Ceiling log2; returns at least 0 and is usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/rr_stream_mux_grant.sv
// rr_grant: combinational rotating-priority encoder.
// Searches req upward starting at ptr, wrapping from N_CH-1 to 0, and returns
// the first requester as a one-hot grant plus its index.
module rr_grant
  import mux_pkg::*;
#(
  parameter int  N_CH  = DEFAULT_N_CH,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] gidx,
  output logic             any
);

  // One extra bit so ptr+k never overflows before the wrap correction.
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_idx;

  // Walk the channels in rotated order and latch onto the first requester.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (w_sum >= (SEL_W+1)'(N_CH)) w_sum = w_sum - (SEL_W+1)'(N_CH);
      w_idx = w_sum[SEL_W-1:0];
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        gidx         = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel round-robin valid/ready mux with one registered
// output stage.
// Optional feature macro PKT_LOCK_EN: when defined, a channel that starts a
// packet (beat with in_last=0) keeps the grant until its in_last beat.
// Without the macro in_last is ignored and every beat is arbitrated alone.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int  N_CH  = DEFAULT_N_CH,
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_next;

  logic             w_load_en;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_grant;
  logic [SEL_W-1:0] w_gidx;
  logic             w_any;
  logic             w_xfer;

  // The output stage can take a new beat when empty or being drained now.
  assign w_load_en = ~r_out_valid | out_ready;

`ifdef PKT_LOCK_EN
  logic            r_lock;
  logic [N_CH-1:0] w_ptr_oh;

  assign w_ptr_oh = {{(N_CH-1){1'b0}}, 1'b1} << r_ptr;
  // While a packet is open only the owning channel may request, even if idle.
  assign w_req    = r_lock ? (in_valid & w_ptr_oh) : in_valid;

  // Lock opens on a non-last beat and closes on the packet's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_lock <= 1'b0;
    else if (w_xfer) r_lock <= ~in_last[w_gidx];
  end
`else
  logic w_unused_last;

  assign w_req         = in_valid;
  assign w_unused_last = ^in_last;
`endif

  rr_grant #(
    .N_CH (N_CH)
  ) u_grant (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .gidx  (w_gidx),
    .any   (w_any)
  );

  assign w_xfer   = w_any & w_load_en;
  // Gating with rst keeps producers from seeing ready during reset.
  assign in_ready = w_grant & {N_CH{w_load_en & ~rst}};

  // Next search start: the channel after the winner, or the winner itself
  // when it has just opened or continued a packet.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_xfer) begin
      w_ptr_next = (w_gidx == SEL_W'(N_CH-1)) ? '0 : w_gidx + 1'b1;
`ifdef PKT_LOCK_EN
      if (!in_last[w_gidx]) w_ptr_next = w_gidx;
`endif
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

  // Output stage: load on transfer, empty on drain without replacement,
  // hold otherwise (back-pressure).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[`MUX_SLICE(w_gidx, WIDTH) +: WIDTH];
      r_out_sel   <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
